// File: rtl/muldiv_pkg.sv
// Shared definitions for the EX-stage multiply/divide unit.
// Holds op encodings, FSM state encodings, the default width and the
// divide special-case constants for that default width.
package muldiv_pkg;

    localparam int MULDIV_XLEN = 32;

    typedef enum logic [2:0] {
        MULDIV_OP_MUL    = 3'd0,
        MULDIV_OP_MULH   = 3'd1,
        MULDIV_OP_MULHSU = 3'd2,
        MULDIV_OP_MULHU  = 3'd3,
        MULDIV_OP_DIV    = 3'd4,
        MULDIV_OP_DIVU   = 3'd5,
        MULDIV_OP_REM    = 3'd6,
        MULDIV_OP_REMU   = 3'd7
    } muldiv_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } muldiv_state_e;

    localparam logic [MULDIV_XLEN-1:0] MULDIV_ALL_ONES = '1;
    localparam logic [MULDIV_XLEN-1:0] MULDIV_SMIN     = {1'b1, {(MULDIV_XLEN-1){1'b0}}};

    // Op bit 2 separates the divide group from the multiply group.
    function automatic logic muldiv_is_div(input logic [2:0] op);
        return op[2];
    endfunction

endpackage

// File: rtl/ex_div_step.sv
// One restoring-division iteration: shift in a dividend bit, trial-subtract divisor.
// Latency: purely combinational.
// Backpressure: none; the parent owns all state and sequencing.
// Ports: rem_i partial remainder, divisor_i divisor magnitude, bit_i next dividend
//        bit (MSB first); rem_o updated remainder, q_o quotient bit for this step.
module ex_div_step #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] rem_i,
    input  logic [XLEN-1:0] divisor_i,
    input  logic            bit_i,
    output logic [XLEN-1:0] rem_o,
    output logic            q_o
);

    // One extra bit: the shifted remainder can reach 2*divisor-1.
    logic [XLEN:0] shifted;
    logic [XLEN:0] diff;

    assign shifted = {rem_i, bit_i};
    assign diff    = shifted - {1'b0, divisor_i};
    assign q_o     = (shifted >= {1'b0, divisor_i});
    // The difference is below the divisor, so it always fits XLEN bits.
    assign rem_o   = q_o ? diff[XLEN-1:0] : shifted[XLEN-1:0];

endmodule

// File: rtl/ex_muldiv.sv
// RV32M/RV64M iterative multiply/divide unit beside the EX-stage ALU.
// Latency: XLEN+1 cycles start-to-done; 1 cycle for divide special cases
//          (and for multiplies when MULDIV_FAST_MUL_EN is defined).
// Backpressure: stallreq_o holds the pipeline while busy; one op at a time,
//          start_i outside IDLE is ignored, cancel_i aborts with no result.
// Ports: clk/rst (sync, active-high); start_i/cancel_i/op_i/reg1_i/reg2_i/wd_i/wreg_i
//        request; stallreq_o, busy_o, done_o, wdata_o, wd_o, wreg_o result side.
// Build option MULDIV_FAST_MUL_EN: single-cycle combinational multiply.
module ex_muldiv
    import muldiv_pkg::*;
#(
    parameter int XLEN  = MULDIV_XLEN,
    parameter int CNT_W = $clog2(XLEN) + 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start_i,
    input  logic            cancel_i,
    input  logic [2:0]      op_i,
    input  logic [XLEN-1:0] reg1_i,
    input  logic [XLEN-1:0] reg2_i,
    input  logic [4:0]      wd_i,
    input  logic            wreg_i,
    output logic            stallreq_o,
    output logic            busy_o,
    output logic            done_o,
    output logic [XLEN-1:0] wdata_o,
    output logic [4:0]      wd_o,
    output logic            wreg_o
);

    localparam logic [XLEN-1:0] ALL_ONES = '1;
    localparam logic [XLEN-1:0] SMIN     = {1'b1, {(XLEN-1){1'b0}}};

    muldiv_state_e     state_q, state_d;
    logic [2:0]        op_q, op_d;
    logic              qneg_q, qneg_d;     // negate product / quotient
    logic              rneg_q, rneg_d;     // negate remainder
    logic [4:0]        wd_q, wd_d;
    logic              wreg_q, wreg_d;
    logic [4:0]        wd_out_q, wd_out_d;
    logic [XLEN-1:0]   wdata_q, wdata_d;
    logic [XLEN-1:0]   mcand_q, mcand_d;   // multiplicand or divisor magnitude
    // Multiply: {partial product high, multiplier shifting out to the right}.
    // Divide:   {partial remainder, dividend shifting out / quotient shifting in}.
    logic [2*XLEN-1:0] prod_q, prod_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    // Request decode
    logic            in_div, sgn1, sgn2, neg1, neg2, div_zero, div_ovf, in_rem;
    logic [XLEN-1:0] mag1, mag2;

    assign in_div   = muldiv_is_div(op_i);
    assign in_rem   = op_i[1];
    assign sgn1     = in_div ? ~op_i[0]
                             : (op_i == MULDIV_OP_MULH) || (op_i == MULDIV_OP_MULHSU);
    assign sgn2     = in_div ? ~op_i[0] : (op_i == MULDIV_OP_MULH);
    assign neg1     = sgn1 & reg1_i[XLEN-1];
    assign neg2     = sgn2 & reg2_i[XLEN-1];
    assign mag1     = neg1 ? -reg1_i : reg1_i;
    assign mag2     = neg2 ? -reg2_i : reg2_i;
    assign div_zero = (reg2_i == '0);
    assign div_ovf  = sgn1 && (reg1_i == SMIN) && (reg2_i == ALL_ONES);

    // Iteration datapath
    logic              last_iter;
    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] mul_next, mul_fin, div_next;
    logic [XLEN-1:0]   div_rem, q_fin, r_fin;
    logic              div_qbit;

    assign last_iter = (cnt_q == CNT_W'(XLEN - 1));
    assign mul_sum   = {1'b0, prod_q[2*XLEN-1:XLEN]} + (prod_q[0] ? {1'b0, mcand_q} : '0);
    assign mul_next  = {mul_sum, prod_q[XLEN-1:1]};
    assign mul_fin   = qneg_q ? -mul_next : mul_next;

    ex_div_step #(.XLEN(XLEN)) u_div_step (
        .rem_i     (prod_q[2*XLEN-1:XLEN]),
        .divisor_i (mcand_q),
        .bit_i     (prod_q[XLEN-1]),
        .rem_o     (div_rem),
        .q_o       (div_qbit)
    );

    assign div_next = {div_rem, prod_q[XLEN-2:0], div_qbit};
    assign q_fin    = qneg_q ? -div_next[XLEN-1:0] : div_next[XLEN-1:0];
    assign r_fin    = rneg_q ? -div_next[2*XLEN-1:XLEN] : div_next[2*XLEN-1:XLEN];

`ifdef MULDIV_FAST_MUL_EN
    // Sign-extending to 2*XLEN+2 bits lets a plain modular multiply produce
    // the signed/unsigned mixed product exactly in the low 2*XLEN bits.
    logic [2*XLEN+1:0] fast_a, fast_b, fast_p;
    assign fast_a = {{(XLEN+2){neg1}}, reg1_i};
    assign fast_b = {{(XLEN+2){neg2}}, reg2_i};
    assign fast_p = fast_a * fast_b;
`endif

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        qneg_d   = qneg_q;
        rneg_d   = rneg_q;
        wd_d     = wd_q;
        wreg_d   = wreg_q;
        wd_out_d = wd_out_q;
        wdata_d  = wdata_q;
        mcand_d  = mcand_q;
        prod_d   = prod_q;
        cnt_d    = cnt_q;

        unique case (state_q)
            ST_IDLE: begin
                if (start_i && !cancel_i) begin
                    op_d   = op_i;
                    wd_d   = wd_i;
                    wreg_d = wreg_i;
                    cnt_d  = '0;
                    if (in_div) begin
                        qneg_d  = neg1 ^ neg2;
                        rneg_d  = neg1;
                        mcand_d = mag2;
                        prod_d  = {{XLEN{1'b0}}, mag1};
                        if (div_zero) begin
                            state_d  = ST_DONE;
                            wdata_d  = in_rem ? reg1_i : ALL_ONES;
                            wd_out_d = wd_i;
                        end else if (div_ovf) begin
                            state_d  = ST_DONE;
                            wdata_d  = in_rem ? '0 : reg1_i;
                            wd_out_d = wd_i;
                        end else begin
                            state_d = ST_DIV;
                        end
                    end else begin
`ifdef MULDIV_FAST_MUL_EN
                        state_d  = ST_DONE;
                        wdata_d  = (op_i == MULDIV_OP_MUL) ? fast_p[XLEN-1:0]
                                                           : fast_p[2*XLEN-1:XLEN];
                        wd_out_d = wd_i;
`else
                        qneg_d  = neg1 ^ neg2;
                        mcand_d = mag1;
                        prod_d  = {{XLEN{1'b0}}, mag2};
                        state_d = ST_MUL;
`endif
                    end
                end
            end
            ST_MUL: begin
                if (cancel_i) begin
                    state_d = ST_IDLE;
                end else begin
                    prod_d = mul_next;
                    cnt_d  = cnt_q + 1'b1;
                    if (last_iter) begin
                        state_d  = ST_DONE;
                        wdata_d  = (op_q == MULDIV_OP_MUL) ? mul_fin[XLEN-1:0]
                                                           : mul_fin[2*XLEN-1:XLEN];
                        wd_out_d = wd_q;
                    end
                end
            end
            ST_DIV: begin
                if (cancel_i) begin
                    state_d = ST_IDLE;
                end else begin
                    prod_d = div_next;
                    cnt_d  = cnt_q + 1'b1;
                    if (last_iter) begin
                        state_d  = ST_DONE;
                        wdata_d  = op_q[1] ? r_fin : q_fin;
                        wd_out_d = wd_q;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            op_q     <= '0;
            qneg_q   <= 1'b0;
            rneg_q   <= 1'b0;
            wd_q     <= '0;
            wreg_q   <= 1'b0;
            wd_out_q <= '0;
            wdata_q  <= '0;
            mcand_q  <= '0;
            prod_q   <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            qneg_q   <= qneg_d;
            rneg_q   <= rneg_d;
            wd_q     <= wd_d;
            wreg_q   <= wreg_d;
            wd_out_q <= wd_out_d;
            wdata_q  <= wdata_d;
            mcand_q  <= mcand_d;
            prod_q   <= prod_d;
            cnt_q    <= cnt_d;
        end
    end

    assign busy_o     = (state_q == ST_MUL) || (state_q == ST_DIV);
    assign stallreq_o = busy_o || ((state_q == ST_IDLE) && start_i && !cancel_i);
    // A flush landing on the result cycle kills the pulse without waiting a cycle.
    assign done_o     = (state_q == ST_DONE) && !cancel_i;
    assign wreg_o     = done_o && wreg_q;
    assign wdata_o    = wdata_q;
    assign wd_o       = wd_out_q;

endmodule

// File: doc/ex_muldiv.md
Name: ex_muldiv

Overview:
Iterative multi-cycle multiply/divide execute unit implementing the RV32M/RV64M operations. It sits beside the single-cycle ALU in the EX stage. It accepts one operation at a time and stalls the pipeline while busy. It returns the result together with the destination register address and write enable, ready for the EX/MEM register.

Parameters:
XLEN, 32, operand/result width in bits (32 or 64)
CNT_W, $clog2(XLEN)+1, iteration counter width

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  reset, synchronous, active-high
start_i  input  1  request a new operation; sampled only in IDLE
cancel_i  input  1  pipeline flush; aborts any operation in flight
op_i  input  3  0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
reg1_i  input  XLEN  rs1 operand (multiplicand/dividend)
reg2_i  input  XLEN  rs2 operand (multiplier/divisor)
wd_i  input  5  destination register address
wreg_i  input  1  destination write enable
stallreq_o  output  1  pipeline stall request
busy_o  output  1  operation in flight (registered)
done_o  output  1  one-cycle pulse, result valid
wdata_o  output  XLEN  result
wd_o  output  5  latched destination address
wreg_o  output  1  latched write enable, gated by done_o

Behaviour:
- Reset: state IDLE. busy_o, done_o, wreg_o and stallreq_o are 0. wdata_o and wd_o are 0. Counter and internal accumulators are 0.
- States: IDLE, MUL, DIV, DONE.
- IDLE with start_i=1 and cancel_i=0: latch op, operands, wd_i and wreg_i; go to MUL (op<4) or DIV (op>=4).
  - Divide by zero and signed overflow take the special cases below and go directly to DONE.
- MUL: shift-add on operand magnitudes, one bit per cycle, XLEN cycles. Then DONE.
- DIV: restoring division on magnitudes, one quotient bit per cycle, XLEN cycles. Then DONE.
- DONE: done_o=1 and wreg_o=latched wreg for exactly one cycle. Then IDLE.
- Latency: done_o asserts XLEN+1 cycles after the start edge for normal ops, and 1 cycle after for special cases.
- Signedness: MULH treats both operands as signed; MULHSU treats rs1 signed and rs2 unsigned; MULHU treats both unsigned; MUL ignores sign.
  - Build a 2*XLEN-bit product of magnitudes and negate it if the operand signs differ.
  - MUL returns product[XLEN-1:0]; the MULH variants return product[2*XLEN-1:XLEN].
- Division signs: the quotient is negative iff the operand signs differ; the remainder takes the sign of the dividend.
- Divide by zero: quotient = all ones; remainder = dividend.
- Signed overflow (DIV/REM with dividend = -2^(XLEN-1) and divisor = -1): quotient = dividend; remainder = 0.
- stallreq_o is combinational: 1 when in MUL or DIV, or when in IDLE with start_i=1 and cancel_i=0. It is 0 in DONE, so the pipeline advances in the same cycle done_o pulses.
- busy_o = state is MUL or DIV.
- start_i outside IDLE is ignored; no queuing.
- cancel_i in any state: next state IDLE, no done_o, wreg_o=0.
  - cancel_i in DONE suppresses the pulse combinationally.
  - cancel_i and start_i in the same IDLE cycle: cancel wins.
- rst mid-operation: return to IDLE and clear all outputs; no done_o.
- wdata_o and wd_o are updated on entry to DONE and hold until the next entry to DONE or reset.

Optional Feature:
MULDIV_FAST_MUL_EN
- Defined: multiply ops skip the MUL state. A combinational 2*XLEN-bit signed multiply is registered, and the unit goes IDLE→DONE with latency 1. Division is unchanged.
- Undefined: iterative multiply as above, latency XLEN+1. No multiplier inferred.

Decomposition:
- Shared package muldiv_pkg: op encodings (MULDIV_OP_MUL … MULDIV_OP_REMU), state encodings, XLEN default, and special-case constants (all-ones, signed minimum).
- Sub-module ex_div_step: combinational one-iteration restoring step. Inputs: partial remainder, divisor, next dividend bit. Outputs: new remainder and quotient bit. The parent holds all state and counter logic.

Test Plan:
- MUL 7 × -3 (0x00000007, 0xFFFFFFFD), XLEN=32 → done_o at cycle 33; wdata_o=0xFFFFFFEB; wd_o and wreg_o match the latched inputs.
- MULH 0x80000000 × 0x80000000 → wdata_o=0x40000000; MULHU of 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE.
- DIV -7 / 2 → 0xFFFFFFFD; REM -7 % 2 → 0xFFFFFFFF; DIVU 100 / 7 → 14; REMU 100 % 7 → 2.
- DIVU 5 / 0 → 0xFFFFFFFF, and REM 5 % 0 → 5, each with done_o 1 cycle after start. DIV 0x80000000 / 0xFFFFFFFF → 0x80000000, and REM of the same operands → 0, each with 1-cycle latency.
- Assert cancel_i at cycle 10 of a DIV → IDLE next cycle, no done_o. A new start_i 2 cycles later completes normally. start_i pulsed while busy → ignored, result unaffected.
- rst at cycle 5 of a MUL → outputs 0 the next cycle, busy_o=0, no done_o. With MULDIV_FAST_MUL_EN defined, MUL 7 × -3 → done_o at cycle 1 with wdata_o=0xFFFFFFEB.
